// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helper for the rate-1/2, K=7 (171/133) Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K       = 7;
    localparam int unsigned NSTATES = 1 << (K - 1);
    localparam logic [K-1:0] G0     = 7'o171;
    localparam logic [K-1:0] G1     = 7'o133;
    localparam int unsigned TBLEN   = 32;
    localparam int unsigned PM_W    = 8;
    localparam logic [PM_W-1:0] INIT_PM = PM_W'(32);
    localparam int unsigned CNT_W   = $clog2(TBLEN + 1);

    // Expected {c1,c0} when input bit u is shifted into encoder state st.
    function automatic logic [1:0] exp_sym(input logic [K-2:0] st, input logic u);
        logic [K-1:0] reg_bits;
        reg_bits = {u, st};
        return {^(reg_bits & G1), ^(reg_bits & G0)};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to the even predecessor.
module viterbi_acs
    import viterbi_pkg::*;
(
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W:0]   pm_o,
    output logic            dec_o
);

    logic [PM_W:0] cand0;
    logic [PM_W:0] cand1;

    always_comb begin
        cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
        cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
        dec_o = (cand1 < cand0);
        pm_o  = dec_o ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder: one symbol in, one bit out after TBLEN symbols.
module viterbi_decoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       RSTn,
    input  logic       d_in_valid,
    input  logic [1:0] d_in,
    output logic       d_out_valid,
    output logic       d_out
);

    localparam logic [PM_W:0] PM_SAT = PM_W'((1 << PM_W) - 1);

    logic [PM_W-1:0]  pm_q [NSTATES];
    logic [PM_W-1:0]  pm_d [NSTATES];
    logic [TBLEN-1:0] sv_q [NSTATES];
    logic [TBLEN-1:0] sv_d [NSTATES];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             d_out_valid_q, d_out_valid_d;

    logic [PM_W:0]    pm_raw [NSTATES];
    logic             dec    [NSTATES];
    logic [PM_W:0]    min_raw;
    logic [K-2:0]     best_idx;
    logic [K-2:0]     best_pred;

    for (genvar t = 0; t < NSTATES; t++) begin : g_acs
        localparam int unsigned P0 = (2 * t) % NSTATES;
        localparam int unsigned P1 = P0 + 1;
        localparam logic        U  = (t >= NSTATES / 2);

        logic [1:0] x0, x1, bm0, bm1;
        assign x0  = d_in ^ exp_sym(6'(P0), U);
        assign x1  = d_in ^ exp_sym(6'(P1), U);
        assign bm0 = {1'b0, x0[1]} + {1'b0, x0[0]};
        assign bm1 = {1'b0, x1[1]} + {1'b0, x1[0]};

        viterbi_acs u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (pm_raw[t]),
            .dec_o (dec[t])
        );
    end

    // Strict '<' keeps the lowest index on ties.
    always_comb begin
        min_raw  = pm_raw[0];
        best_idx = '0;
        for (int unsigned i = 1; i < NSTATES; i++) begin
            if (pm_raw[i] < min_raw) begin
                min_raw  = pm_raw[i];
                best_idx = 6'(i);
            end
        end
        best_pred = {best_idx[4:0], dec[best_idx]};
    end

    always_comb begin
        logic [PM_W:0] norm;
        logic [K-2:0]  pred;
        pm_d          = pm_q;
        sv_d          = sv_q;
        cnt_d         = cnt_q;
        d_out_d       = d_out_q;
        d_out_valid_d = 1'b0;
        norm          = '0;
        pred          = '0;
        if (d_in_valid) begin
            for (int unsigned i = 0; i < NSTATES; i++) begin
                norm     = pm_raw[i] - min_raw;
                pm_d[i]  = (norm > PM_SAT) ? PM_SAT[PM_W-1:0] : norm[PM_W-1:0];
                pred     = {i[4:0], dec[i]};
                sv_d[i]  = {sv_q[pred][TBLEN-2:0], i[5]};
            end
            // Take the bit leaving the best path's register, so bit n-TBLEN appears on symbol n.
            d_out_d       = sv_q[best_pred][TBLEN-1];
            d_out_valid_d = (cnt_q == CNT_W'(TBLEN));
            if (cnt_q != CNT_W'(TBLEN)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned i = 0; i < NSTATES; i++) begin
                pm_q[i] <= (i == 0) ? '0 : INIT_PM;
                sv_q[i] <= '0;
            end
            cnt_q         <= '0;
            d_out_q       <= 1'b0;
            d_out_valid_q <= 1'b0;
        end else begin
            pm_q          <= pm_d;
            sv_q          <= sv_d;
            cnt_q         <= cnt_d;
            d_out_q       <= d_out_d;
            d_out_valid_q <= d_out_valid_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_out_valid = d_out_valid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: encodes frames, queues info bits, compares decoded output.
module tb_viterbi_decoder;

    localparam int unsigned NINFO = 512;
    localparam int unsigned NSYM  = 544;
    localparam logic [6:0] TG0 = 7'o171;
    localparam logic [6:0] TG1 = 7'o133;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       d_in_valid = 1'b0;
    logic [1:0] d_in = 2'b00;
    logic       d_out_valid;
    logic       d_out;

    int   checks = 0;
    int   failures = 0;
    int   acc_cnt;
    int   out_cnt = 0;
    logic exp_q[$];
    logic msg[NINFO];

    viterbi_decoder dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .d_in_valid  (d_in_valid),
        .d_in        (d_in),
        .d_out_valid (d_out_valid),
        .d_out       (d_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) acc_cnt <= 0;
        else if (d_in_valid) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (!RSTn) begin
            out_cnt = 0;
        end else if (d_out_valid) begin
            if (out_cnt == 0) check_eq("first_latency", acc_cnt, 33);
            if (exp_q.size() == 0) check_eq("extra_output", 1, 0);
            else check_eq($sformatf("bit%0d", out_cnt), d_out, exp_q.pop_front());
            out_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        RSTn = 1'b0;
        d_in_valid = 1'b0;
        d_in = 2'b00;
        #1;
        check_eq("rst_valid", d_out_valid, 0);
        check_eq("rst_dout", d_out, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        RSTn = 1'b1;
    endtask

    task automatic drive(input logic [1:0] s);
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) check_eq("gap_valid", d_out_valid, 0);
            d_in_valid = 1'b0;
        end
    endtask

    // Encodes msg (then 00 flush symbols), optionally with bit flips and input gaps.
    task automatic run_frame(input bit flips, input bit gaps, input int nsym);
        logic [5:0] st;
        logic [6:0] r;
        logic [1:0] sym;
        logic       u;
        st = '0;
        for (int n = 0; n < nsym; n++) begin
            if (n < NINFO) begin
                u   = msg[n];
                r   = {u, st};
                sym = {^(r & TG1), ^(r & TG0)};
                st  = {u, st[5:1]};
            end else begin
                u   = 1'b0;
                sym = 2'b00;
            end
            if (flips && (n % 40 == 20)) sym = sym ^ ((n % 80 == 20) ? 2'b01 : 2'b10);
            if (gaps && (n == 100 || n == 300)) idle(4);
            drive(sym);
            if (n < NINFO) exp_q.push_back(u);
        end
        if (nsym == NSYM) begin
            @(negedge clk);
            d_in_valid = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check_eq("out_count", out_cnt, NINFO);
            check_eq("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        foreach (msg[i]) msg[i] = 1'b0;
        run_frame(1'b0, 1'b0, NSYM);

        do_reset();
        msg[0] = 1'b1;
        run_frame(1'b0, 1'b0, NSYM);

        do_reset();
        foreach (msg[i]) msg[i] = (i < NINFO - 6) ? 1'($urandom) : 1'b0;
        run_frame(1'b0, 1'b0, NSYM);

        do_reset();
        run_frame(1'b1, 1'b0, NSYM);

        do_reset();
        run_frame(1'b0, 1'b1, NSYM);

        do_reset();
        run_frame(1'b0, 1'b0, 200);
        do_reset();
        foreach (msg[i]) msg[i] = (i < NINFO - 6) ? 1'($urandom) : 1'b0;
        run_frame(1'b0, 1'b0, NSYM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
